// File: rtl/floppy_track_streamer.sv
// Streams a track out of a synchronous SRAM as MSB-first flux pulses with a
// once-per-revolution index pulse; the track repeats endlessly while enabled.
//
// state      | meaning
// IDLE       | outputs quiet, byte pointer held at 0, no SRAM access
// PRIME_REQ  | one-cycle read request for byte 0
// PRIME_WAIT | byte 0 returns; loaded into the shifter on exit
// STREAM     | serialising cells, prefetching the next byte once per byte
module floppy_track_streamer #(
    parameter int BIT_DIV    = 16,
    parameter int TRACK_LEN  = 6250,
    parameter int PULSE_CLKS = 4,
    parameter int INDEX_CLKS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [12:0] ram_addr,
    output logic        ram_rw,
    output logic        ram_en,
    input  logic [7:0]  ram_data,
    output logic        rd_pulse,
    output logic        rd_bit,
    output logic        index,
    output logic        streaming
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int IDX_W = $clog2(INDEX_CLKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] PULSE_END = DIV_W'(PULSE_CLKS);
    localparam logic [12:0]      PTR_LAST  = 13'(TRACK_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LOAD  = IDX_W'(INDEX_CLKS);

    typedef enum logic [1:0] {IDLE, PRIME_REQ, PRIME_WAIT, STREAM} state_t;

    function automatic logic [12:0] wrap_inc(input logic [12:0] p);
        return (p == PTR_LAST) ? 13'd0 : p + 13'd1;
    endfunction

    state_t           state_q, state_d;
    logic [12:0]      ptr_q, ptr_d, nxt_ptr;
    logic [7:0]       shifter_q, shifter_d;
    logic [7:0]       next_byte_q, next_byte_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_cnt_q, idx_cnt_d;
    logic             rd_valid_q, rd_valid_d;
    logic [12:0]      ram_addr_q, ram_addr_d;
    logic             ram_en_q, ram_en_d;
    logic             rd_pulse_q, rd_pulse_d;
    logic             rd_bit_q, rd_bit_d;
    logic             index_q, index_d;
    logic             streaming_q, streaming_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        nxt_ptr     = wrap_inc(ptr_q);
        shifter_d   = shifter_q;
        next_byte_d = next_byte_q;
        bit_idx_d   = bit_idx_q;
        div_cnt_d   = div_cnt_q;
        idx_cnt_d   = (idx_cnt_q != '0) ? idx_cnt_q - IDX_W'(1) : '0;
        rd_valid_d  = ~ram_en_q;
        ram_addr_d  = ram_addr_q;
        ram_en_d    = 1'b1;

        case (state_q)
            IDLE: begin
                ptr_d     = '0;
                idx_cnt_d = '0;
                if (enable) begin
                    state_d    = PRIME_REQ;
                    ram_en_d   = 1'b0;
                    ram_addr_d = '0;
                end
            end
            PRIME_REQ: state_d = PRIME_WAIT;
            PRIME_WAIT: begin
                state_d    = STREAM;
                shifter_d  = ram_data;
                bit_idx_d  = '0;
                div_cnt_d  = '0;
                ptr_d      = '0;
                idx_cnt_d  = IDX_LOAD;
                ram_en_d   = 1'b0;
                ram_addr_d = wrap_inc(13'd0);
            end
            STREAM: begin
                // Prefetched byte lands two edges after its request.
                if (rd_valid_q) next_byte_d = ram_data;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        shifter_d  = next_byte_q;
                        bit_idx_d  = '0;
                        ptr_d      = nxt_ptr;
                        ram_en_d   = 1'b0;
                        ram_addr_d = wrap_inc(nxt_ptr);
                        if (nxt_ptr == 13'd0) idx_cnt_d = IDX_LOAD;
                    end else begin
                        shifter_d = {shifter_q[6:0], 1'b0};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropping enable abandons everything, including a read in flight.
        if (!enable) begin
            state_d    = IDLE;
            ptr_d      = '0;
            bit_idx_d  = '0;
            div_cnt_d  = '0;
            idx_cnt_d  = '0;
            rd_valid_d = 1'b0;
            ram_en_d   = 1'b1;
            ram_addr_d = '0;
        end

        streaming_d = (state_d == STREAM);
        rd_bit_d    = streaming_d & shifter_d[7];
        rd_pulse_d  = rd_bit_d & (div_cnt_d < PULSE_END);
        index_d     = streaming_d & (idx_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            shifter_q   <= '0;
            next_byte_q <= '0;
            bit_idx_q   <= '0;
            div_cnt_q   <= '0;
            idx_cnt_q   <= '0;
            rd_valid_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_en_q    <= 1'b1;
            rd_pulse_q  <= 1'b0;
            rd_bit_q    <= 1'b0;
            index_q     <= 1'b0;
            streaming_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            shifter_q   <= shifter_d;
            next_byte_q <= next_byte_d;
            bit_idx_q   <= bit_idx_d;
            div_cnt_q   <= div_cnt_d;
            idx_cnt_q   <= idx_cnt_d;
            rd_valid_q  <= rd_valid_d;
            ram_addr_q  <= ram_addr_d;
            ram_en_q    <= ram_en_d;
            rd_pulse_q  <= rd_pulse_d;
            rd_bit_q    <= rd_bit_d;
            index_q     <= index_d;
            streaming_q <= streaming_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_rw    = 1'b1;
    assign ram_en    = ram_en_q;
    assign rd_pulse  = rd_pulse_q;
    assign rd_bit    = rd_bit_q;
    assign index     = index_q;
    assign streaming = streaming_q;

endmodule

// File: tb/tb_floppy_track_streamer.sv
// Directed bench for floppy_track_streamer: 4-byte track, 4 clk per cell,
// compared cycle by cycle against a timeline model of the expected stream.
module tb_floppy_track_streamer;
    localparam int BIT_DIV    = 4;
    localparam int TRACK_LEN  = 4;
    localparam int PULSE_CLKS = 1;
    localparam int INDEX_CLKS = 8;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        enable = 1'b0;
    logic [12:0] ram_addr;
    logic        ram_rw, ram_en;
    wire  [7:0]  ram_data;
    logic        rd_pulse, rd_bit, index, streaming;

    logic [7:0]  mem [4];
    logic [7:0]  rd_q     = 8'h00;
    logic        rd_valid = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt, index_cnt;

    floppy_track_streamer #(
        .BIT_DIV(BIT_DIV), .TRACK_LEN(TRACK_LEN),
        .PULSE_CLKS(PULSE_CLKS), .INDEX_CLKS(INDEX_CLKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_en(ram_en),
        .ram_data(ram_data), .rd_pulse(rd_pulse), .rd_bit(rd_bit),
        .index(index), .streaming(streaming)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data valid for one cycle after an enabled edge.
    always @(posedge clk) begin
        rd_valid <= ~ram_en;
        rd_q     <= mem[ram_addr[1:0]];
    end
    assign ram_data = rd_valid ? rd_q : 8'hzz;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ram"}, 16'({ram_addr, ram_en, ram_rw}), 16'({13'd0, 1'b1, 1'b1}));
        chk({tag, "_outs"}, 16'({rd_pulse, rd_bit, index, streaming}), 16'd0);
    endtask

    task automatic start_seq();
        enable = 1'b1;
        step();
        chk("e0_ram_en", 16'(ram_en), 16'd0);
        chk("e0_ram_addr", 16'(ram_addr), 16'd0);
        chk("e0_streaming", 16'(streaming), 16'd0);
        step();
        chk("e1_ram_en", 16'(ram_en), 16'd1);
        chk("e1_streaming", 16'(streaming), 16'd0);
        chk("e1_index", 16'(index), 16'd0);
        step();
    endtask

    // k = clk cycles since the first cell started; cells are 4 clk, bytes 32, revs 128.
    task automatic run_stream(input int n);
        int  byte_i, bitpos;
        logic expb;
        pulse_cnt = 0;
        index_cnt = 0;
        for (int k = 0; k < n; k++) begin
            byte_i = (k / 32) % 4;
            bitpos = 7 - ((k % 32) / 4);
            expb   = mem[byte_i][bitpos];
            chk("rd_bit", 16'(rd_bit), 16'(expb));
            chk("rd_pulse", 16'(rd_pulse), 16'(expb && (k % 4 == 0)));
            chk("index", 16'(index), 16'((k % 128) < 8));
            chk("ram_en", 16'(ram_en), 16'((k % 32) != 0));
            chk("ram_addr", 16'(ram_addr), 16'(((k / 32) + 1) % 4));
            chk("streaming", 16'(streaming), 16'd1);
            pulse_cnt += int'(rd_pulse);
            index_cnt += int'(index);
            if (k % 128 == 127) begin
                chk("pulses_per_rev", 16'(pulse_cnt), 16'd14);
                chk("index_per_rev", 16'(index_cnt), 16'd8);
                pulse_cnt = 0;
                index_cnt = 0;
            end
            if (k != n - 1) step();
        end
    endtask

    initial begin
        mem[0] = 8'hA5;
        mem[1] = 8'h00;
        mem[2] = 8'hFF;
        mem[3] = 8'h81;

        #1 rst_n = 1'b0;
        #3 check_reset_vals("reset");
        step();
        check_reset_vals("reset_clocked");
        rst_n = 1'b1;
        step();
        step();
        chk("idle_ram_en", 16'(ram_en), 16'd1);
        chk("idle_streaming", 16'(streaming), 16'd0);

        // Over eight revolutions, ending on a cell start inside byte 2 (0xFF).
        start_seq();
        run_stream(8 * 128 + 73);

        enable = 1'b0;
        step();
        chk("drop_streaming", 16'(streaming), 16'd0);
        chk("drop_rd_pulse", 16'(rd_pulse), 16'd0);
        chk("drop_ram_en", 16'(ram_en), 16'd1);
        chk("drop_index", 16'(index), 16'd0);
        chk("drop_rd_bit", 16'(rd_bit), 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_no_access", 16'(ram_en), 16'd1);
        end

        // Restart from byte 0, then reset during the second prefetch cycle.
        start_seq();
        run_stream(33);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid_fetch");
        enable = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_ram_en", 16'(ram_en), 16'd1);
            chk("post_rst_streaming", 16'(streaming), 16'd0);
        end

        start_seq();
        run_stream(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
